// File: rtl/vga_layer_compositor.sv
// Composites prioritised overlay layers onto a VGA stream in two pipeline stages and
// applies a frame-synchronous global fade paced by the 1 ms tick.
module vga_layer_compositor #(
    parameter int unsigned NUM_LAYERS   = 4,
    parameter int unsigned COLOR_W      = 4,
    parameter int unsigned FADE_STEP_MS = 32,
    parameter int unsigned PIPE         = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            one_ms_tick,
    input  logic [10:0]                     hcount_in,
    input  logic [10:0]                     vcount_in,
    input  logic                            hsync_in,
    input  logic                            vsync_in,
    input  logic                            hblnk_in,
    input  logic                            vblnk_in,
    input  logic [3*COLOR_W-1:0]            bg_rgb_in,
    input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb_in,
    input  logic [NUM_LAYERS-1:0]           layer_opaque_in,
    input  logic [NUM_LAYERS-1:0]           layer_en,
    input  logic                            fade_start,
    input  logic                            fade_dir,
    output logic [10:0]                     hcount_out,
    output logic [10:0]                     vcount_out,
    output logic                            hsync_out,
    output logic                            vsync_out,
    output logic                            hblnk_out,
    output logic                            vblnk_out,
    output logic [3*COLOR_W-1:0]            rgb_out,
    output logic                            fade_busy,
    output logic [3:0]                      fade_level,
    output logic                            fade_done
);

    localparam int unsigned RGB_W  = 3 * COLOR_W;
    localparam int unsigned PROD_W = COLOR_W + 4;
    localparam int unsigned TCNT_W = (FADE_STEP_MS > 1) ? $clog2(FADE_STEP_MS) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(FADE_STEP_MS - 1);

    // The pixel path is hard-wired to two register stages.
    if (PIPE != 2) begin : g_pipe_check
        $error("vga_layer_compositor supports PIPE == 2 only");
    end

    typedef enum logic {IDLE, FADING} fade_state_t;

    fade_state_t       state, state_n;
    logic [3:0]        pend_lvl, pend_n;
    logic [TCNT_W-1:0] tcnt, tcnt_n;
    logic              dir, dir_n;
    logic              done_n;

    logic [RGB_W-1:0]  sel_rgb_c;
    logic [RGB_W-1:0]  scaled_c;
    logic [RGB_W-1:0]  s1_rgb;
    logic [10:0]       s1_hcount, s1_vcount;
    logic              s1_hsync, s1_vsync, s1_hblnk, s1_vblnk;
    logic              vblnk_q;

    // Stage 1 select: later (higher) layers override earlier ones.
    always_comb begin
        sel_rgb_c = bg_rgb_in;
        for (int i = 0; i < int'(NUM_LAYERS); i++) begin
            if (layer_en[i] && layer_opaque_in[i]) begin
                sel_rgb_c = layer_rgb_in[i*RGB_W +: RGB_W];
            end
        end
    end

    // Stage 2 fade: c * (level+1) >> 4, so level 15 is identity.
    always_comb begin
        logic [PROD_W-1:0] prod;
        logic [4:0]        mult;
        scaled_c = '0;
        mult     = 5'({1'b0, fade_level} + 5'd1);
        for (int c = 0; c < 3; c++) begin
            prod = PROD_W'(s1_rgb[c*COLOR_W +: COLOR_W]) * PROD_W'(mult);
            scaled_c[c*COLOR_W +: COLOR_W] = prod[PROD_W-1:4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_rgb     <= '0;
            s1_hcount  <= '0;
            s1_vcount  <= '0;
            s1_hsync   <= 1'b0;
            s1_vsync   <= 1'b0;
            s1_hblnk   <= 1'b0;
            s1_vblnk   <= 1'b0;
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            s1_rgb     <= sel_rgb_c;
            s1_hcount  <= hcount_in;
            s1_vcount  <= vcount_in;
            s1_hsync   <= hsync_in;
            s1_vsync   <= vsync_in;
            s1_hblnk   <= hblnk_in;
            s1_vblnk   <= vblnk_in;
            hcount_out <= s1_hcount;
            vcount_out <= s1_vcount;
            hsync_out  <= s1_hsync;
            vsync_out  <= s1_vsync;
            hblnk_out  <= s1_hblnk;
            vblnk_out  <= s1_vblnk;
            rgb_out    <= (s1_hblnk || s1_vblnk) ? '0 : scaled_c;
        end
    end

    // Applied level only follows the pending level at the start of vertical blanking.
    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_q    <= 1'b0;
            fade_level <= 4'hF;
        end else begin
            vblnk_q <= vblnk_in;
            if (vblnk_in && !vblnk_q) begin
                fade_level <= pend_lvl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pend_lvl  <= 4'hF;
            tcnt      <= '0;
            dir       <= 1'b1;
            fade_done <= 1'b0;
            fade_busy <= 1'b0;
        end else begin
            state     <= state_n;
            pend_lvl  <= pend_n;
            tcnt      <= tcnt_n;
            dir       <= dir_n;
            fade_done <= done_n;
            fade_busy <= (state_n == FADING);
        end
    end

    // Fade sequencer; a start request has priority over a coincident tick.
    always_comb begin
        state_n = state;
        pend_n  = pend_lvl;
        tcnt_n  = tcnt;
        dir_n   = dir;
        done_n  = 1'b0;
        if (fade_start) begin
            dir_n  = fade_dir;
            tcnt_n = '0;
            if (pend_lvl == {4{fade_dir}}) begin
                done_n  = 1'b1;
                state_n = IDLE;
            end else begin
                state_n = FADING;
            end
        end else if (state == FADING && one_ms_tick) begin
            if (tcnt == TCNT_LAST) begin
                tcnt_n = '0;
                if (pend_lvl != {4{dir}}) begin
                    pend_n = dir ? 4'(pend_lvl + 4'd1) : 4'(pend_lvl - 4'd1);
                end
                if (pend_n == {4{dir}}) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end else begin
                tcnt_n = TCNT_W'(tcnt + TCNT_W'(1));
            end
        end
    end

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Directed bench for vga_layer_compositor: pixel path, layer priority, fade sequencing, reset.
module tb_vga_layer_compositor;

    localparam int unsigned NL = 4;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          one_ms_tick;
    logic [10:0]   hcount_in, vcount_in;
    logic          hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0]   bg_rgb_in;
    logic [47:0]   layer_rgb_in;
    logic [3:0]    layer_opaque_in, layer_en;
    logic          fade_start, fade_dir;
    logic [10:0]   hcount_out, vcount_out;
    logic          hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0]   rgb_out;
    logic          fade_busy;
    logic [3:0]    fade_level;
    logic          fade_done;

    int checks   = 0;
    int failures = 0;

    vga_layer_compositor #(
        .NUM_LAYERS(NL), .COLOR_W(CW), .FADE_STEP_MS(2), .PIPE(2)
    ) dut (
        .clk(clk), .rst(rst), .one_ms_tick(one_ms_tick),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .bg_rgb_in(bg_rgb_in), .layer_rgb_in(layer_rgb_in),
        .layer_opaque_in(layer_opaque_in), .layer_en(layer_en),
        .fade_start(fade_start), .fade_dir(fade_dir),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .fade_busy(fade_busy),
        .fade_level(fade_level), .fade_done(fade_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(output logic done_seen);
        one_ms_tick = 1'b1;
        step();
        done_seen   = fade_done;
        one_ms_tick = 1'b0;
        step();
    endtask

    task automatic ticks(input int n);
        logic d;
        for (int i = 0; i < n; i++) tick(d);
    endtask

    task automatic start_fade(input logic dir);
        fade_start = 1'b1;
        fade_dir   = dir;
        step();
        fade_start = 1'b0;
    endtask

    task automatic vblank_pulse();
        vblnk_in = 1'b1;
        step();
        vblnk_in = 1'b0;
        step();
    endtask

    initial begin
        logic d;
        int   done_at;
        rst = 1'b1; one_ms_tick = 1'b0;
        hcount_in = '0; vcount_in = '0;
        hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
        bg_rgb_in = '0; layer_rgb_in = '0; layer_opaque_in = '0; layer_en = '0;
        fade_start = 1'b0; fade_dir = 1'b0;
        step(); step();
        rst = 1'b0;

        check("rst_rgb", 32'(rgb_out), 32'h0);
        check("rst_level", 32'(fade_level), 32'hF);
        check("rst_busy", 32'(fade_busy), 32'h0);

        // Background only, pipeline latency of two cycles
        bg_rgb_in = 12'h123; hcount_in = 11'd5; vcount_in = 11'd7; hsync_in = 1'b1;
        step();
        check("lat1_hcount", 32'(hcount_out), 32'd0);
        check("lat1_rgb", 32'(rgb_out), 32'h0);
        step();
        check("bg_rgb", 32'(rgb_out), 32'h123);
        check("bg_hcount", 32'(hcount_out), 32'd5);
        check("bg_vcount", 32'(vcount_out), 32'd7);
        check("bg_hsync", 32'(hsync_out), 32'd1);
        hblnk_in = 1'b1;
        step(); step();
        check("hblank_rgb", 32'(rgb_out), 32'h0);
        check("hblank_out", 32'(hblnk_out), 32'd1);
        hblnk_in = 1'b0;

        // Layer priority; layer 1 opaque but disabled must not win
        layer_rgb_in = {12'h00F, 12'h0F0, 12'hABC, 12'hF00};
        layer_opaque_in = 4'b0111;
        layer_en = 4'b0101;
        step(); step();
        check("prio_l2", 32'(rgb_out), 32'h0F0);
        layer_en = 4'b0001;
        step(); step();
        check("prio_l0", 32'(rgb_out), 32'hF00);
        layer_en = 4'b0000; layer_opaque_in = 4'b0000;

        // Fade in while already at full level
        start_fade(1'b1);
        check("fin_full_done", 32'(fade_done), 32'd1);
        check("fin_full_busy", 32'(fade_busy), 32'd0);
        step();
        check("fin_full_done_clr", 32'(fade_done), 32'd0);

        // Fade out: 8 steps of 2 ticks reaches level 7
        start_fade(1'b0);
        check("fout_busy", 32'(fade_busy), 32'd1);
        ticks(16);
        check("fout_level_held", 32'(fade_level), 32'hF);
        vblank_pulse();
        check("fout_level7", 32'(fade_level), 32'd7);
        bg_rgb_in = 12'hFFF;
        step(); step();
        check("lvl7_rgb", 32'(rgb_out), 32'h777);

        // Remaining 14 ticks; done must arrive on tick 30 overall
        done_at = 0;
        for (int i = 17; i <= 40; i++) begin
            tick(d);
            if (d) begin
                done_at = i;
                break;
            end
        end
        check("fout_done_tick", 32'(done_at), 32'd30);
        check("fout_idle", 32'(fade_busy), 32'd0);
        check("fout_level_prevb", 32'(fade_level), 32'd7);
        vblank_pulse();
        check("fout_level0", 32'(fade_level), 32'd0);
        step(); step();
        check("lvl0_rgb", 32'(rgb_out), 32'h000);

        // Reset restores full level
        rst = 1'b1; step(); rst = 1'b0;
        check("rst2_level", 32'(fade_level), 32'hF);
        step(); step();
        check("rst2_rgb", 32'(rgb_out), 32'hFFF);

        // Fade out to 9, then reverse with a coincident tick that must be ignored
        start_fade(1'b0);
        ticks(12);
        vblank_pulse();
        check("rev_level9", 32'(fade_level), 32'd9);
        one_ms_tick = 1'b1;
        start_fade(1'b1);
        one_ms_tick = 1'b0;
        step();
        check("rev_busy", 32'(fade_busy), 32'd1);
        ticks(2);
        vblank_pulse();
        check("rev_level10", 32'(fade_level), 32'd10);
        done_at = 0;
        for (int i = 3; i <= 20; i++) begin
            tick(d);
            if (d) begin
                done_at = i;
                break;
            end
        end
        check("rev_done_tick", 32'(done_at), 32'd12);
        vblank_pulse();
        check("rev_level15", 32'(fade_level), 32'hF);

        // Reset in the middle of a fade at level 5
        start_fade(1'b0);
        ticks(20);
        vblank_pulse();
        check("mid_level5", 32'(fade_level), 32'd5);
        check("mid_busy", 32'(fade_busy), 32'd1);
        rst = 1'b1;
        step();
        check("midrst_rgb", 32'(rgb_out), 32'h0);
        check("midrst_hcount", 32'(hcount_out), 32'd0);
        check("midrst_level", 32'(fade_level), 32'hF);
        check("midrst_busy", 32'(fade_busy), 32'd0);
        check("midrst_done", 32'(fade_done), 32'd0);
        rst = 1'b0;
        ticks(4);
        check("midrst_done_later", 32'(fade_done), 32'd0);
        check("midrst_busy_later", 32'(fade_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
